// File: rtl/window_line_buffer.sv
// Sliding (2R+1)x(2R+1) window generator over a raster pixel stream.
// Emits only windows that lie fully inside the frame; carries centre coordinates and an end-of-frame flag.
module window_line_buffer #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int R      = 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  input  logic [DATA_W-1:0]                          in_pix,
  input  logic                                       in_sof,
  output logic [(2*R+1)*(2*R+1)*DATA_W-1:0]          win,
  output logic                                       out_valid,
  output logic                                       out_eof,
  output logic [$clog2(IMG_W)-1:0]                   out_col,
  output logic [$clog2(IMG_H)-1:0]                   out_row
);

  localparam int K  = 2*R + 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]     col, eff_col, nxt_col;
  logic [RW-1:0]     row, eff_row, nxt_row;
  logic              interior, last_pix;
  logic [DATA_W-1:0] lb      [K-1][IMG_W];
  logic [DATA_W-1:0] w       [K][K];
  logic [DATA_W-1:0] new_col [K];

  // sof forces the current pixel to (0,0) regardless of where the counters were
  always_comb begin
    eff_col = in_sof ? '0 : col;
    eff_row = in_sof ? '0 : row;
    nxt_col = eff_col + CW'(1);
    nxt_row = eff_row;
    if (eff_col == CW'(IMG_W-1)) begin
      nxt_col = '0;
      nxt_row = (eff_row == RW'(IMG_H-1)) ? '0 : eff_row + RW'(1);
    end
    interior = (eff_row >= RW'(2*R)) && (eff_col >= CW'(2*R));
    last_pix = (eff_row == RW'(IMG_H-1)) && (eff_col == CW'(IMG_W-1));
    for (int k = 0; k < K-1; k++) begin
      new_col[k] = lb[k][eff_col];
    end
    new_col[K-1] = in_pix;
  end

  // Line buffers hold no reset so they can map onto block RAM; stale data is masked by the guards
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int k = 0; k < K-1; k++) begin
        lb[k][eff_col] <= new_col[k+1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      out_col   <= '0;
      out_row   <= '0;
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K; j++) begin
          w[i][j] <= '0;
        end
      end
    end else begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      if (in_valid) begin
        for (int i = 0; i < K; i++) begin
          for (int j = 0; j < K-1; j++) begin
            w[i][j] <= w[i][j+1];
          end
          w[i][K-1] <= new_col[i];
        end
        col       <= nxt_col;
        row       <= nxt_row;
        out_valid <= interior;
        out_eof   <= interior && last_pix;
        out_col   <= eff_col - CW'(R);
        out_row   <= eff_row - RW'(R);
      end
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      assign win[(gi*K+gj)*DATA_W +: DATA_W] = w[gi][gj];
    end
  end

endmodule

// File: tb/tb_window_line_buffer.sv
// Directed bench for window_line_buffer: R=1 and R=2 instances on an 8x6 frame,
// pixel value = base + row*16 + col.
module tb_window_line_buffer;

  localparam int W = 8;
  localparam int H = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_sof;
  logic [7:0]   in_pix;
  logic [71:0]  win1;
  logic [199:0] win2;
  logic         ov1, oe1, ov2, oe2;
  logic [2:0]   oc1, or1, oc2, or2;

  int           errors = 0;
  int           checks = 0;
  int           n_win1, n_win2;
  logic [199:0] last_exp1;
  bit           last_int1;

  always #5 clk = ~clk;

  window_line_buffer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .R(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pix(in_pix), .in_sof(in_sof),
    .win(win1), .out_valid(ov1), .out_eof(oe1), .out_col(oc1), .out_row(or1));

  window_line_buffer #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .R(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pix(in_pix), .in_sof(in_sof),
    .win(win2), .out_valid(ov2), .out_eof(oe2), .out_col(oc2), .out_row(or2));

  task automatic checkOutput(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the edge that consumed them
  task automatic applyStimulus(input logic v, input logic [7:0] p, input logic s);
    in_valid = v;
    in_pix   = p;
    in_sof   = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [199:0] expWin(input int rad, input int base, input int r, input int c);
    logic [199:0] v;
    int k;
    k = 2*rad + 1;
    v = '0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        v[(i*k+j)*8 +: 8] = 8'(base + (r-2*rad+i)*16 + (c-2*rad+j));
    return v;
  endfunction

  task automatic sendPixel(input int base, input int r, input int c, input bit sof);
    bit v1, v2;
    logic [199:0] e;
    applyStimulus(1'b1, 8'(base + r*16 + c), sof);
    v1 = (r >= 2) && (c >= 2);
    v2 = (r >= 4) && (c >= 4);
    if (ov1) n_win1++;
    if (ov2) n_win2++;
    checkOutput("out_valid_r1", ov1, v1);
    checkOutput("out_eof_r1", oe1, v1 && r == H-1 && c == W-1);
    checkOutput("out_valid_r2", ov2, v2);
    checkOutput("out_eof_r2", oe2, v2 && r == H-1 && c == W-1);
    if (v1) begin
      e = expWin(1, base, r, c);
      checkOutput("win_r1", win1, e);
      checkOutput("out_row_r1", or1, r-1);
      checkOutput("out_col_r1", oc1, c-1);
      last_exp1 = e;
    end
    if (v2) begin
      checkOutput("win_r2", win2, expWin(2, base, r, c));
      checkOutput("out_row_r2", or2, r-2);
      checkOutput("out_col_r2", oc2, c-2);
    end
    last_int1 = v1;
  endtask

  // Idle cycle: a stray sof without valid must be ignored and the window must hold
  task automatic sendGap();
    applyStimulus(1'b0, 8'hEE, 1'b1);
    checkOutput("gap_valid_r1", ov1, 1'b0);
    checkOutput("gap_valid_r2", ov2, 1'b0);
    if (last_int1) checkOutput("gap_win_hold_r1", win1, last_exp1);
  endtask

  task automatic sendFrame(input int base, input bit sof_first, input bit gaps);
    n_win1 = 0;
    n_win2 = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        sendPixel(base, r, c, sof_first && r == 0 && c == 0);
        if (gaps) sendGap();
      end
    end
    checkOutput("frame_count_r1", n_win1, 24);
    checkOutput("frame_count_r2", n_win2, 8);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pix    = '0;
    in_sof    = 1'b0;
    last_exp1 = '0;
    last_int1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", ov1, 1'b0);
    checkOutput("reset_eof", oe1, 1'b0);
    checkOutput("reset_win_r1", win1, '0);
    checkOutput("reset_win_r2", win2, '0);
    checkOutput("reset_row", or1, '0);
    checkOutput("reset_col", oc1, '0);
    rst = 1'b0;

    $display("[TB] continuous frame, no sof");
    sendFrame(0, 1'b0, 1'b0);

    $display("[TB] gapped frame");
    sendFrame(0, 1'b1, 1'b1);

    $display("[TB] sof on 21st pixel");
    for (int idx = 0; idx < 20; idx++) sendPixel(8'h80, idx / W, idx % W, idx == 0);
    sendFrame(0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-frame");
    for (int idx = 0; idx < 19; idx++) sendPixel(0, idx / W, idx % W, idx == 0);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", ov1, 1'b0);
    checkOutput("async_rst_eof", oe1, 1'b0);
    checkOutput("async_rst_win_r1", win1, '0);
    checkOutput("async_rst_win_r2", win2, '0);
    #1 rst = 1'b0;
    sendFrame(0, 1'b0, 1'b0);

    $display("[TB] back-to-back frames");
    sendFrame(0, 1'b1, 1'b0);
    sendFrame(8'h80, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
